// File: rtl/comp_result_monitor.sv
// Result monitor for a registered Gt/Lt/Eq comparator: saturating per-class counters, Gt run alarm, sticky error flag.
// Optional macro COMP_MON_IRQ_EN adds the one-cycle AlarmPulse output on ALARM entry.
module comp_result_monitor #(
   parameter int CNT_W      = 16,
   parameter int RUN_THRESH = 4
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Valid,
   input  logic             Gt,
   input  logic             Lt,
   input  logic             Eq,
   input  logic             Clear,
   output logic [CNT_W-1:0] GtCount,
   output logic [CNT_W-1:0] LtCount,
   output logic [CNT_W-1:0] EqCount,
   output logic [CNT_W-1:0] RunLen,
   output logic             Alarm,
`ifdef COMP_MON_IRQ_EN
   output logic             ErrFlag,
   output logic             AlarmPulse
`else
   output logic             ErrFlag
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

   localparam logic [CNT_W-1:0] SAT    = '1;
   localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

   logic                       legal;
   logic [2:0]                 hit;
   logic [2:0][CNT_W-1:0]      cnt_all;
   state_t                     state_reg, state_next;
   logic [CNT_W-1:0]           run_reg, run_next;
   logic                       err_reg, err_next;

   // Exactly one flag high; zero or several flags is an illegal encoding.
   assign legal = (Gt & ~Lt & ~Eq) | (~Gt & Lt & ~Eq) | (~Gt & ~Lt & Eq);
   assign hit   = {Eq, Lt, Gt} & {3{Valid & legal & ~Clear}};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n)
               cnt_reg <= '0;
            else if (Clear)
               cnt_reg <= '0;
            else if (hit[gi] && cnt_reg != SAT)
               cnt_reg <= cnt_reg + 1'b1;
         end
         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   assign GtCount = cnt_all[0];
   assign LtCount = cnt_all[1];
   assign EqCount = cnt_all[2];

   always_comb begin
      state_next = state_reg;
      run_next   = run_reg;
      err_next   = err_reg;
      if (Clear) begin
         state_next = IDLE;
         run_next   = '0;
         err_next   = 1'b0;
      end else if (Valid) begin
         if (!legal) begin
            err_next   = 1'b1;
            run_next   = '0;
            state_next = IDLE;
         end else if (Gt) begin
            run_next = (run_reg == SAT) ? run_reg : run_reg + 1'b1;
            // ALARM is held even once RunLen saturates and no longer equals the threshold
            if (state_reg == ALARM)
               state_next = ALARM;
            else if (run_next == THRESH)
               state_next = ALARM;
            else
               state_next = RUN;
         end else begin
            run_next   = '0;
            state_next = IDLE;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= IDLE;
         run_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         run_reg   <= run_next;
         err_reg   <= err_next;
      end
   end

   assign RunLen  = run_reg;
   assign ErrFlag = err_reg;
   assign Alarm   = (state_reg == ALARM);

`ifdef COMP_MON_IRQ_EN
   logic pulse_reg;
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
         pulse_reg <= 1'b0;
      else
         pulse_reg <= (state_next == ALARM) && (state_reg != ALARM);
   end
   assign AlarmPulse = pulse_reg;
`endif

endmodule

// File: tb/tb_comp_result_monitor.sv
// Directed bench for comp_result_monitor: main instance (CNT_W=16, RUN_THRESH=4) and a
// narrow instance (CNT_W=4, RUN_THRESH=15) sharing the same stimulus for saturation.
`timescale 1ns/1ps
module tb_comp_result_monitor;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Valid = 1'b0, Gt = 1'b0, Lt = 1'b0, Eq = 1'b0, Clear = 1'b0;
   logic [15:0] GtCount, LtCount, EqCount, RunLen;
   logic        Alarm, ErrFlag;
   logic [3:0]  s_gt, s_lt, s_eq, s_run;
   logic        s_alarm, s_err;
`ifdef COMP_MON_IRQ_EN
   logic        AlarmPulse, s_pulse;
`endif

   int errors = 0;
   int checks = 0;

   always #5 Clock = ~Clock;

   comp_result_monitor #(.CNT_W(16), .RUN_THRESH(4)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Valid(Valid), .Gt(Gt), .Lt(Lt), .Eq(Eq), .Clear(Clear),
      .GtCount(GtCount), .LtCount(LtCount), .EqCount(EqCount), .RunLen(RunLen),
      .Alarm(Alarm),
`ifdef COMP_MON_IRQ_EN
      .ErrFlag(ErrFlag), .AlarmPulse(AlarmPulse)
`else
      .ErrFlag(ErrFlag)
`endif
   );

   comp_result_monitor #(.CNT_W(4), .RUN_THRESH(15)) dut_s (
      .Clock(Clock), .Reset_n(Reset_n), .Valid(Valid), .Gt(Gt), .Lt(Lt), .Eq(Eq), .Clear(Clear),
      .GtCount(s_gt), .LtCount(s_lt), .EqCount(s_eq), .RunLen(s_run),
      .Alarm(s_alarm),
`ifdef COMP_MON_IRQ_EN
      .ErrFlag(s_err), .AlarmPulse(s_pulse)
`else
      .ErrFlag(s_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic g, input logic l, input logic e, input logic c);
      @(negedge Clock);
      Valid = v; Gt = g; Lt = l; Eq = e; Clear = c;
      @(posedge Clock);
      #1;
   endtask

   task automatic sg();  step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endtask
   task automatic sl();  step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); endtask
   task automatic se();  step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); endtask
   task automatic gap(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic clr(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

   initial begin
      #3;
      chk("rst_gt", GtCount, 0); chk("rst_lt", LtCount, 0); chk("rst_eq", EqCount, 0);
      chk("rst_run", RunLen, 0); chk("rst_alarm", Alarm, 0); chk("rst_err", ErrFlag, 0);
`ifdef COMP_MON_IRQ_EN
      chk("rst_pulse", AlarmPulse, 0);
`endif
      @(negedge Clock); Reset_n = 1'b1;

      // mid-run asynchronous reset
      sg(); sg(); sg();
      chk("pre_rst_gt", GtCount, 3); chk("pre_rst_run", RunLen, 3);
      @(negedge Clock); Reset_n = 1'b0; Valid = 1'b0; Gt = 1'b0;
      #1;
      chk("async_rst_gt", GtCount, 0); chk("async_rst_run", RunLen, 0); chk("async_rst_alarm", Alarm, 0);
      @(negedge Clock); Reset_n = 1'b1;
      gap();
      chk("post_rst_gt", GtCount, 0); chk("post_rst_run", RunLen, 0);

      // run broken by Lt
      sg(); chk("brk_run1", RunLen, 1); chk("brk_alarm1", Alarm, 0);
      sg(); chk("brk_run2", RunLen, 2); chk("brk_alarm2", Alarm, 0);
      sg(); chk("brk_run3", RunLen, 3); chk("brk_alarm3", Alarm, 0);
      sl(); chk("brk_run0", RunLen, 0); chk("brk_alarm0", Alarm, 0);
      chk("brk_gt", GtCount, 3); chk("brk_lt", LtCount, 1); chk("brk_eq", EqCount, 0);

      // alarm entry with gaps, exit on Eq
      sg(); gap(); sg(); gap(); sg(); chk("al_run3", RunLen, 3); chk("al_alarm3", Alarm, 0);
      gap(); chk("al_gap_run", RunLen, 3);
      sg(); chk("al_run4", RunLen, 4); chk("al_alarm4", Alarm, 1);
`ifdef COMP_MON_IRQ_EN
      chk("al_pulse4", AlarmPulse, 1);
`endif
      gap(); chk("al_gap_alarm", Alarm, 1);
`ifdef COMP_MON_IRQ_EN
      chk("al_pulse_gap", AlarmPulse, 0);
`endif
      sg(); chk("al_run5", RunLen, 5); chk("al_alarm5", Alarm, 1);
`ifdef COMP_MON_IRQ_EN
      chk("al_pulse5", AlarmPulse, 0);
`endif
      se(); chk("al_exit_alarm", Alarm, 0); chk("al_exit_run", RunLen, 0);
      chk("al_exit_eq", EqCount, 1); chk("al_gt", GtCount, 8);

      // illegal encodings
      sg(); sg(); chk("ill_pre_run", RunLen, 2); chk("ill_pre_gt", GtCount, 10);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("ill1_err", ErrFlag, 1); chk("ill1_run", RunLen, 0);
      chk("ill1_gt", GtCount, 10); chk("ill1_lt", LtCount, 1); chk("ill1_eq", EqCount, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill2_err", ErrFlag, 1); chk("ill2_run", RunLen, 0);
      chk("ill2_gt", GtCount, 10); chk("ill2_lt", LtCount, 1); chk("ill2_eq", EqCount, 1);
      gap(); chk("ill_sticky", ErrFlag, 1);
      // FSM was returned to IDLE: alarm only after 4 fresh Gt
      sg(); sg(); sg(); chk("ill_re_alarm3", Alarm, 0);
      sg(); chk("ill_re_alarm4", Alarm, 1); chk("ill_re_gt", GtCount, 14);
`ifdef COMP_MON_IRQ_EN
      chk("ill_re_pulse", AlarmPulse, 1);
`endif
      // illegal sample while in ALARM
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("ill_alarm_exit", Alarm, 0); chk("ill_alarm_gt", GtCount, 14);
      sg(); sg(); sg(); sg(); chk("pre_clr_alarm", Alarm, 1); chk("pre_clr_gt", GtCount, 18);

      // clear beats a same-cycle Gt
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("clr_gt", GtCount, 0); chk("clr_lt", LtCount, 0); chk("clr_eq", EqCount, 0);
      chk("clr_run", RunLen, 0); chk("clr_err", ErrFlag, 0); chk("clr_alarm", Alarm, 0);
`ifdef COMP_MON_IRQ_EN
      chk("clr_pulse", AlarmPulse, 0);
`endif
      sg(); chk("clr_after_gt", GtCount, 1); chk("clr_after_run", RunLen, 1);

      // saturation on the narrow instance
      clr();
      chk("sat_clr_eq", s_eq, 0);
      for (int i = 1; i <= 20; i++) begin
         se();
         if (i == 14) chk("sat_eq14", s_eq, 14);
         if (i == 15) chk("sat_eq15", s_eq, 15);
      end
      chk("sat_eq20", s_eq, 15);
      for (int i = 1; i <= 20; i++) begin
         sg();
         if (i == 14) begin chk("sat_run14", s_run, 14); chk("sat_alarm14", s_alarm, 0); end
         if (i == 15) begin chk("sat_run15", s_run, 15); chk("sat_alarm15", s_alarm, 1); end
      end
      chk("sat_run20", s_run, 15); chk("sat_alarm20", s_alarm, 1); chk("sat_gt20", s_gt, 15);
      chk("sat_err", s_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
